// File: rtl/lane_bit_packer.sv
// lane_bit_packer: two independent serial-to-parallel lane engines that turn
// the 1-to-2 demux output into WORD_W-bit words (LSB first), each with a
// one-entry valid/ready output register and a sticky overflow flag.

// Per-lane engine: bit assembly, output register, overflow flag.
module lane_bit_packer_lane #(
    parameter int WORD_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_in,
    input  logic              vld,
    input  logic              ready,
    input  logic              ovf_clr,
    output logic [WORD_W-1:0] word,
    output logic              word_valid,
    output logic              overflow
);
    localparam int CW = $clog2(WORD_W);

    logic [WORD_W-2:0] sr;
    logic [CW-1:0]     cnt;
    logic              done;
    logic              free;

    // A word completes when the last bit position is filled; the output
    // register can take it if empty or draining this very cycle.
    always_comb begin
        done = vld && (cnt == CW'(WORD_W-1));
        free = !word_valid || ready;
    end

    // Shift register and bit counter: each accepted bit lands at position cnt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr  <= '0;
            cnt <= '0;
        end else if (vld) begin
            for (int i = 0; i < WORD_W-1; i++)
                if (cnt == CW'(i)) sr[i] <= bit_in;
            cnt <= done ? '0 : cnt + 1'b1;
        end
    end

    // Output register: load on completion when free, drop valid after a
    // transfer otherwise; data held while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word       <= '0;
            word_valid <= 1'b0;
        end else if (done && free) begin
            word       <= {bit_in, sr};
            word_valid <= 1'b1;
        end else if (word_valid && ready) begin
            word_valid <= 1'b0;
        end
    end

    // Sticky overflow: a dropped word sets it, and wins over a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)               overflow <= 1'b0;
        else if (done && !free) overflow <= 1'b1;
        else if (ovf_clr)      overflow <= 1'b0;
    end
endmodule

// Top: two lane engines, one per demux output bit.
module lane_bit_packer #(
    parameter int WORD_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        bit_in,
    input  logic [1:0]        lane_vld,
    output logic [WORD_W-1:0] word0,
    output logic              word0_valid,
    input  logic              word0_ready,
    output logic [WORD_W-1:0] word1,
    output logic              word1_valid,
    input  logic              word1_ready,
    output logic [1:0]        overflow,
    input  logic              ovf_clr
);
    localparam int NUM_LANES = 2;

    logic [NUM_LANES-1:0][WORD_W-1:0] word_arr;
    logic [NUM_LANES-1:0]             valid_arr;
    logic [NUM_LANES-1:0]             ready_arr;

    assign ready_arr   = {word1_ready, word0_ready};
    assign word0       = word_arr[0];
    assign word1       = word_arr[1];
    assign word0_valid = valid_arr[0];
    assign word1_valid = valid_arr[1];

    for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
        lane_bit_packer_lane #(.WORD_W(WORD_W)) u_lane (
            .clk        (clk),
            .rst        (rst),
            .bit_in     (bit_in[n]),
            .vld        (lane_vld[n]),
            .ready      (ready_arr[n]),
            .ovf_clr    (ovf_clr),
            .word       (word_arr[n]),
            .word_valid (valid_arr[n]),
            .overflow   (overflow[n])
        );
    end
endmodule
